video_ram_shared: RTL and testbench

//  Parametrised single-array video RAM shared by two clients: display scanout (read-only, top priority)
//  and CPU bus (read/write, buffered). CPU writes queue in a small FIFO and drain in idle display cycles.
//  CPU reads wait for the FIFO to drain, then return data with a valid pulse.

---
 rtl/video_ram_pkg.sv | 17 +
 rtl/video_ram_wr_fifo.sv | 68 ++++++
 rtl/video_ram_shared.sv | 185 ++++++++++++++++++
 tb/tb_video_ram_shared.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_ram_pkg.sv
// Shared definitions for the video RAM: arbiter grant codes and FIFO sizing helper.
// Optional clear engine is enabled by defining VIDEO_RAM_CLEAR_EN.
package video_ram_pkg;

  // One array access per cycle; these codes name who owns it.
  localparam logic [2:0] GNT_NONE   = 3'd0;
  localparam logic [2:0] GNT_DISP   = 3'd1;
  localparam logic [2:0] GNT_CPU_RD = 3'd2;
  localparam logic [2:0] GNT_CPU_WR = 3'd3;
  localparam logic [2:0] GNT_CLR    = 3'd4;

  // Pointer width for a power-of-two FIFO of at least two entries.
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/video_ram_wr_fifo.sv
// CPU write FIFO: holds {addr,data} entries until an idle array slot drains them.
// Push is ignored when full, pop is ignored when empty; push+pop keeps the count.
module video_ram_wr_fifo
  import video_ram_pkg::*;
#(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
)(
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            push_data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            pop_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [fifo_ptr_w(DEPTH):0]  count_o
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = store_q[rd_ptr_q];
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;

  // Next pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since occupancy gates their use.
  always_ff @(posedge clk_i) begin
    if (push_ok) store_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/video_ram_shared.sv
// Single-port video RAM shared by display scanout (top priority, never stalled)
// and a buffered CPU port. Grant order: display read, CPU read (FIFO empty),
// FIFO drain write, clear write. Define VIDEO_RAM_CLEAR_EN to build the clear engine.
module video_ram_shared
  import video_ram_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 14,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
)(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              DISP_REQ,
  input  logic [ADDR_W-1:0] DISP_ADDR,
  output logic [DATA_W-1:0] DISP_DATA,
  output logic              DISP_VALID,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_READY,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              CPU_RVALID,
  input  logic              CLR_START,
  output logic              CLR_BUSY
);

  localparam int ENT_W = ADDR_W + DATA_W;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] ram_q;

  logic [2:0]        gnt;
  logic              mem_re, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ENT_W-1:0]  fifo_rdata;
  logic [fifo_ptr_w(FIFO_DEPTH):0] fifo_count_unused;

  logic              rd_pending_q, rd_pending_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              disp_valid_q, cpu_rvalid_q;
  logic [DATA_W-1:0] disp_hold_q, cpu_hold_q;
  logic              cpu_accept;

  logic              clr_busy;
  logic [ADDR_W-1:0] clr_ptr;

  video_ram_wr_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i       (CLK),
    .rst_n_i     (RESET_N),
    .push_i      (fifo_push),
    .push_data_i ({CPU_ADDR, CPU_WDATA}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count_unused)
  );

  assign CPU_READY  = !fifo_full && !rd_pending_q && !clr_busy;
  assign cpu_accept = CPU_REQ && CPU_READY;
  assign fifo_push  = cpu_accept && CPU_WE;
  assign fifo_pop   = (gnt == GNT_CPU_WR);

  // Fixed-priority arbiter: picks the single array access for this cycle.
  always_comb begin
    gnt       = GNT_NONE;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = DISP_ADDR;
    mem_wdata = fifo_rdata[DATA_W-1:0];
    if (!RESET_N) begin
      gnt = GNT_NONE;
    end else if (DISP_REQ) begin
      gnt      = GNT_DISP;
      mem_re   = 1'b1;
      mem_addr = DISP_ADDR;
    end else if (rd_pending_q && fifo_empty) begin
      gnt      = GNT_CPU_RD;
      mem_re   = 1'b1;
      mem_addr = rd_addr_q;
    end else if (!fifo_empty) begin
      gnt       = GNT_CPU_WR;
      mem_we    = 1'b1;
      mem_addr  = fifo_rdata[ENT_W-1:DATA_W];
      mem_wdata = fifo_rdata[DATA_W-1:0];
    end else if (clr_busy) begin
      gnt       = GNT_CLR;
      mem_we    = 1'b1;
      mem_addr  = clr_ptr;
      mem_wdata = CLEAR_VAL;
    end
  end

  // Block RAM: one access per cycle, synchronous read into ram_q.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) ram_q <= mem[mem_addr];
  end

  // CPU read bookkeeping: latch on accept, release when the read is issued.
  always_comb begin
    rd_pending_d = rd_pending_q;
    rd_addr_d    = rd_addr_q;
    if (cpu_accept && !CPU_WE) begin
      rd_pending_d = 1'b1;
      rd_addr_d    = CPU_ADDR;
    end else if (gnt == GNT_CPU_RD) begin
      rd_pending_d = 1'b0;
    end
  end

  // Read-pending, valid strobes and output hold registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      disp_valid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      disp_hold_q  <= '0;
      cpu_hold_q   <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_addr_q    <= rd_addr_d;
      disp_valid_q <= (gnt == GNT_DISP);
      cpu_rvalid_q <= (gnt == GNT_CPU_RD);
      disp_hold_q  <= DISP_DATA;
      cpu_hold_q   <= CPU_RDATA;
    end
  end

  // Each client sees RAM data only in its valid cycle, otherwise its last value.
  assign DISP_VALID = disp_valid_q;
  assign DISP_DATA  = disp_valid_q ? ram_q : disp_hold_q;
  assign CPU_RVALID = cpu_rvalid_q;
  assign CPU_RDATA  = cpu_rvalid_q ? ram_q : cpu_hold_q;
  assign CLR_BUSY   = clr_busy;

`ifdef VIDEO_RAM_CLEAR_EN
  logic              clr_busy_q, clr_busy_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  // Clear engine: sweeps every address, advancing only on granted slots.
  always_comb begin
    clr_busy_d = clr_busy_q;
    clr_ptr_d  = clr_ptr_q;
    if (!clr_busy_q) begin
      if (CLR_START) begin
        clr_busy_d = 1'b1;
        clr_ptr_d  = '0;
      end
    end else if (gnt == GNT_CLR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (&clr_ptr_q) clr_busy_d = 1'b0;
    end
  end

  // Clear engine state registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      clr_busy_q <= 1'b0;
      clr_ptr_q  <= '0;
    end else begin
      clr_busy_q <= clr_busy_d;
      clr_ptr_q  <= clr_ptr_d;
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_ptr  = clr_ptr_q;
`else
  logic unused_clr_start;
  assign unused_clr_start = CLR_START;
  assign clr_busy         = 1'b0;
  assign clr_ptr          = '0;
`endif

endmodule

// File: tb/tb_video_ram_shared.sv
// Scoreboard bench for video_ram_shared: stimulus pushes expected responses,
// a negedge monitor pops and compares on DISP_VALID / CPU_RVALID.
module tb_video_ram_shared;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam logic [DW-1:0] CLRV = 8'h5A;

  logic          CLK, RESET_N;
  logic          DISP_REQ;
  logic [AW-1:0] DISP_ADDR;
  logic [DW-1:0] DISP_DATA;
  logic          DISP_VALID;
  logic          CPU_REQ, CPU_WE;
  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_WDATA;
  logic          CPU_READY;
  logic [DW-1:0] CPU_RDATA;
  logic          CPU_RVALID;
  logic          CLR_START, CLR_BUSY;

  video_ram_shared #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(4), .CLEAR_VAL(CLRV)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_DATA(DISP_DATA), .DISP_VALID(DISP_VALID),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_READY(CPU_READY), .CPU_RDATA(CPU_RDATA), .CPU_RVALID(CPU_RVALID),
    .CLR_START(CLR_START), .CLR_BUSY(CLR_BUSY)
  );

  typedef struct { logic [DW-1:0] data; int cyc; } disp_exp_t;

  disp_exp_t     disp_q[$];
  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] mem_m [2**AW];   // reference memory: value of the newest accepted write
  logic [AW-1:0] written[$];
  int            vectors = 0, miscompares = 0;
  int            cyc = 0;
  int            disp_mode = 0;   // 0 off, 1 held, 2 random, 3 toggle, 4 fixed addr
  logic [AW-1:0] disp_fix_addr = '0;
  logic          rst_q = 1'b0;
  logic [DW-1:0] last_disp = '0, last_cpu = '0;
  disp_exp_t     mon_e;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    rst_q <= RESET_N;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented response against the scoreboard queues.
  always @(negedge CLK) begin
    if (!rst_q) begin
      last_disp = '0;
      last_cpu  = '0;
    end else begin
      if (DISP_VALID) begin
        if (disp_q.size() == 0) check("disp_unexpected_valid", 1, 0);
        else begin
          mon_e = disp_q.pop_front();
          check("disp_data", DISP_DATA, mon_e.data);
          check("disp_latency", cyc, mon_e.cyc);
        end
        last_disp = DISP_DATA;
      end else begin
        check("disp_hold", DISP_DATA, last_disp);
        if (disp_q.size() > 0 && disp_q[0].cyc <= cyc) begin
          void'(disp_q.pop_front());
          check("disp_missing_valid", 0, 1);
        end
      end
      if (CPU_RVALID) begin
        if (cpu_q.size() == 0) check("cpu_unexpected_rvalid", 1, 0);
        else check("cpu_rdata", CPU_RDATA, cpu_q.pop_front());
        last_cpu = CPU_RDATA;
      end else begin
        check("cpu_rdata_hold", CPU_RDATA, last_cpu);
      end
    end
  end

  // One clock: drive display per mode, record expectations, advance to just after the edge.
  task automatic step(output bit acc);
    disp_exp_t e;
    acc = 1'b0;
    case (disp_mode)
      0: DISP_REQ = 1'b0;
      1: DISP_REQ = 1'b1;
      2: DISP_REQ = 1'($urandom_range(0, 1));
      3: DISP_REQ = !DISP_REQ;
      default: DISP_REQ = 1'b1;
    endcase
    DISP_ADDR = (disp_mode == 4) ? disp_fix_addr : AW'($urandom_range(0, 63));
    if (RESET_N && DISP_REQ) begin
      e.data = mem_m[DISP_ADDR];
      e.cyc  = cyc + 1;
      disp_q.push_back(e);
    end
    if (RESET_N && CPU_REQ && CPU_READY) begin
      acc = 1'b1;
      if (CPU_WE) begin
        mem_m[CPU_ADDR] = CPU_WDATA;
        written.push_back(CPU_ADDR);
      end else begin
        cpu_q.push_back(mem_m[CPU_ADDR]);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic cpu_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    int n;
    n = 0;
    CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = a; CPU_WDATA = d;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 3000);
    CPU_REQ = 1'b0;
    if (!acc) check("cpu_accept_timeout", 0, 1);
    $display("txn %s addr=%03h data=%02h after %0d cycles", we ? "WR" : "RD", a, d, n);
  endtask

  task automatic wait_rsp();
    bit acc;
    int n;
    n = 0;
    while (cpu_q.size() > 0 && n < 3000) begin
      step(acc);
      n++;
    end
    if (cpu_q.size() > 0) begin
      check("cpu_rvalid_timeout", 0, 1);
      cpu_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] old_a, old_b;
    bit acc;
    int n;

    RESET_N = 1'b0; DISP_REQ = 1'b0; DISP_ADDR = '0;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0; CLR_START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_disp_valid", DISP_VALID, 0);
    check("rst_disp_data", DISP_DATA, 0);
    check("rst_cpu_ready", CPU_READY, 1);
    check("rst_cpu_rvalid", CPU_RVALID, 0);
    check("rst_cpu_rdata", CPU_RDATA, 0);
    check("rst_clr_busy", CLR_BUSY, 0);
    RESET_N = 1'b1;

    // Preload the display region and drain it with a read.
    for (int i = 0; i < 64; i++) cpu_txn(1'b1, AW'(i), DW'($urandom));
    cpu_txn(1'b0, AW'(63), '0);
    wait_rsp();

    // Display read of 0x010 held for three cycles.
    disp_fix_addr = AW'(16); disp_mode = 4;
    idle(3);
    disp_mode = 0;
    idle(2);

    // Simple write then read back.
    cpu_txn(1'b1, AW'(12'h100), 8'hA5);
    cpu_txn(1'b0, AW'(12'h100), '0);
    wait_rsp();

    // Display starves the CPU: FIFO fills, then drains on release.
    disp_mode = 1;
    for (int i = 0; i < 4; i++) cpu_txn(1'b1, AW'(12'h300 + i), DW'($urandom));
    check("full_ready_low", CPU_READY, 0);
    idle(3);
    check("starved_ready_low", CPU_READY, 0);
    disp_mode = 0;
    idle(4);
    check("drained_ready_high", CPU_READY, 1);
    for (int i = 0; i < 4; i++) cpu_txn(1'b0, AW'(12'h300 + i), '0);
    wait_rsp();

    // Read-after-write with display toggling.
    disp_mode = 3;
    cpu_txn(1'b1, AW'(12'h200), 8'h11);
    cpu_txn(1'b0, AW'(12'h200), '0);
    wait_rsp();
    disp_mode = 0;
    idle(3);

    // Randomized mixed traffic.
    disp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = written[$urandom_range(0, written.size() - 1)];
        cpu_txn(1'b0, a, '0);
      end else begin
        cpu_txn(1'b1, AW'($urandom_range(12'h100, 12'h3EF)), DW'($urandom));
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    wait_rsp();
    disp_mode = 0;
    idle(2);

`ifdef VIDEO_RAM_CLEAR_EN
    CLR_START = 1'b1;
    step(acc);
    CLR_START = 1'b0;
    check("clr_busy_start", CLR_BUSY, 1);
    check("clr_ready_low", CPU_READY, 0);
    n = 0;
    while (CLR_BUSY && n < 5000) begin
      n++;
      step(acc);
    end
    check("clr_busy_cycles", n, 2**AW);
    for (int i = 0; i < 2**AW; i++) mem_m[i] = CLRV;
    for (int i = 0; i < 16; i++) cpu_txn(1'b0, AW'($urandom), '0);
    wait_rsp();
    disp_mode = 2;
    idle(64);
    disp_mode = 0;
    idle(2);
`else
    CLR_START = 1'b1;
    step(acc);
    CLR_START = 1'b0;
    check("noclr_busy", CLR_BUSY, 0);
    step(acc);
    check("noclr_busy_later", CLR_BUSY, 0);
    check("noclr_ready", CPU_READY, 1);
    cpu_txn(1'b0, AW'(12'h100), '0);
    wait_rsp();
`endif

    // Reset with a read pending and two queued writes.
    cpu_txn(1'b1, AW'(12'h3F0), 8'h33);
    cpu_txn(1'b1, AW'(12'h3F1), 8'h44);
    cpu_txn(1'b0, AW'(12'h3F0), '0);
    wait_rsp();
    old_a = mem_m[12'h3F0];
    old_b = mem_m[12'h3F1];
    disp_mode = 1;
    cpu_txn(1'b1, AW'(12'h3F0), 8'hC3);
    cpu_txn(1'b1, AW'(12'h3F1), 8'h3C);
    cpu_txn(1'b0, AW'(12'h3F1), '0);
    RESET_N = 1'b0; DISP_REQ = 1'b0; disp_mode = 0;
    cpu_q.delete();
    mem_m[12'h3F0] = old_a;
    mem_m[12'h3F1] = old_b;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("rst6_cpu_ready", CPU_READY, 1);
    check("rst6_cpu_rvalid", CPU_RVALID, 0);
    check("rst6_disp_valid", DISP_VALID, 0);
    check("rst6_clr_busy", CLR_BUSY, 0);
    RESET_N = 1'b1;
    idle(5);
    cpu_txn(1'b0, AW'(12'h3F0), '0);
    cpu_txn(1'b0, AW'(12'h3F1), '0);
    wait_rsp();
    idle(3);

    check("disp_queue_empty", disp_q.size(), 0);
    check("cpu_queue_empty", cpu_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
